// File: rtl/ebus_pkg.sv
// Shared types and bus widths for the EBOX EBUS arbiter slice.
package ebus_pkg;

  localparam int unsigned EBUS_DATA_W = 36;
  localparam int unsigned EBUS_CS_W   = 7;
  localparam int unsigned EBUS_FUNC_W = 3;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    DEMAND,
    DONE
  } tEbusState;

endpackage

// File: rtl/rr_pick.sv
// Combinational winner select: fixed-priority index first, else round-robin from rr.
module rr_pick
  import ebus_pkg::*;
#(
  parameter int unsigned NREQ     = 7,
  parameter int unsigned PRIO_IDX = 6,
  parameter int unsigned IDXW     = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDXW-1:0] rr,
  output logic [NREQ-1:0] winner
);

  logic [IDXW-1:0] idx;
  logic            found;

  always_comb begin
    winner = '0;
    idx    = '0;
    found  = 1'b0;
    if (req[PRIO_IDX]) begin
      winner[PRIO_IDX] = 1'b1;
    end else begin
      for (int unsigned k = 0; k < NREQ; k++) begin
        idx = IDXW'((32'(rr) + k) % NREQ);
        if (!found && req[idx]) begin
          winner[idx] = 1'b1;
          found       = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/ebus_arbiter.sv
// EBUS owner arbitration, setup/demand/transfer handshake with timeout, and bus output mux.
module ebus_arbiter
  import ebus_pkg::*;
#(
  parameter int unsigned NREQ     = 7,
  parameter int unsigned PRIO_IDX = 6,
  parameter int unsigned TMO      = 15
) (
  input  logic                        clk,
  input  logic                        rstN,
  input  logic [NREQ-1:0]             req,
  input  logic [NREQ*EBUS_DATA_W-1:0] reqData,
  input  logic [NREQ*EBUS_CS_W-1:0]   reqCS,
  input  logic [NREQ*EBUS_FUNC_W-1:0] reqFunc,
  input  logic                        xfer,
  output logic [NREQ-1:0]             grant,
  output logic [EBUS_DATA_W-1:0]      ebusData,
  output logic [EBUS_CS_W-1:0]        ebusCS,
  output logic [EBUS_FUNC_W-1:0]      ebusFunc,
  output logic                        ebusPar,
  output logic                        demand,
  output logic [NREQ-1:0]             done,
  output logic                        tmoErr,
  output logic                        busy
);

  localparam int unsigned IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned CNTW = $clog2(TMO + 1);

  tEbusState       state_q, state_d;
  logic [NREQ-1:0] grant_q, grant_d;
  logic [IDXW-1:0] owner_q, owner_d;
  logic [IDXW-1:0] rr_q, rr_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic            demand_q, demand_d;
  logic [NREQ-1:0] done_q, done_d;
  logic            tmo_q, tmo_d;

  logic [NREQ-1:0] pick;
  logic [IDXW-1:0] pick_idx;

  rr_pick #(
    .NREQ    (NREQ),
    .PRIO_IDX(PRIO_IDX),
    .IDXW    (IDXW)
  ) u_pick (
    .req   (req),
    .rr    (rr_q),
    .winner(pick)
  );

  always_comb begin
    pick_idx = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (pick[i]) pick_idx = IDXW'(i);
    end
  end

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    owner_d  = owner_q;
    rr_d     = rr_q;
    cnt_d    = cnt_q;
    demand_d = demand_q;
    done_d   = '0;
    tmo_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (|req) begin
          grant_d = pick;
          owner_d = pick_idx;
          state_d = SETUP;
        end
      end
      SETUP: begin
        if (!req[owner_q]) begin
          grant_d = '0;
          state_d = IDLE;
        end else begin
          demand_d = 1'b1;
          cnt_d    = '0;
          state_d  = DEMAND;
        end
      end
      DEMAND: begin
        // Abort beats xfer; xfer beats the terminal count.
        if (!req[owner_q]) begin
          grant_d  = '0;
          demand_d = 1'b0;
          state_d  = IDLE;
        end else if (xfer) begin
          demand_d        = 1'b0;
          done_d[owner_q] = 1'b1;
          state_d         = DONE;
        end else if (cnt_q == CNTW'(TMO - 1)) begin
          demand_d = 1'b0;
          tmo_d    = 1'b1;
          state_d  = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        grant_d = '0;
        state_d = IDLE;
        if (owner_q != IDXW'(PRIO_IDX)) begin
          rr_d = (owner_q == IDXW'(NREQ - 1)) ? '0 : owner_q + 1'b1;
        end
      end
      default: begin
        grant_d  = '0;
        demand_d = 1'b0;
        state_d  = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      owner_q  <= '0;
      rr_q     <= '0;
      cnt_q    <= '0;
      demand_q <= 1'b0;
      done_q   <= '0;
      tmo_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      owner_q  <= owner_d;
      rr_q     <= rr_d;
      cnt_q    <= cnt_d;
      demand_q <= demand_d;
      done_q   <= done_d;
      tmo_q    <= tmo_d;
    end
  end

  logic [EBUS_DATA_W-1:0] data_m;
  logic [EBUS_CS_W-1:0]   cs_m;
  logic [EBUS_FUNC_W-1:0] func_m;

  always_comb begin
    data_m = '0;
    cs_m   = '0;
    func_m = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (grant_q[i]) begin
        data_m = data_m | reqData[EBUS_DATA_W*i +: EBUS_DATA_W];
        cs_m   = cs_m   | reqCS[EBUS_CS_W*i +: EBUS_CS_W];
        func_m = func_m | reqFunc[EBUS_FUNC_W*i +: EBUS_FUNC_W];
      end
    end
  end

  assign grant    = grant_q;
  assign ebusData = data_m;
  assign ebusCS   = cs_m;
  assign ebusFunc = func_m;
  assign ebusPar  = ~^data_m;
  assign demand   = demand_q;
  assign done     = done_q;
  assign tmoErr   = tmo_q;
  assign busy     = (state_q != IDLE);

endmodule
